// File: rtl/sci_pkg.sv
// Shared definitions for the SCI serial receiver and transmitter: frame defaults and receiver FSM encoding.
package sci_pkg;

  localparam int SCI_OSR_DEF    = 7;
  localparam int SCI_SAMPLE_DEF = 3;
  localparam int SCI_DATA_W     = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } sci_rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sci_rx_sync.sv
// Two-flop resynchroniser for the asynchronous rxd line plus falling-edge detect.
// All flops reset to 1 (idle line level) so no false edge comes out of reset.
module sci_rx_sync (
  input  logic baud_clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Shift the line through the synchroniser and keep one cycle of history.
  always_comb begin
    meta_d = rxd;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchroniser and history registers.
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rxd_s = sync_q;
  assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/sci_rx.sv
// UART-style byte receiver (start, 8 data LSB first, stop) with valid/ack holding register and error flags.
// Define SCI_RX_MAJORITY_EN to decide each bit by 2-of-3 vote around SAMPLE_POS (needs 1 <= SAMPLE_POS <= OSR-2).
module sci_rx
  import sci_pkg::*;
#(
  parameter int OSR        = SCI_OSR_DEF,
  parameter int SAMPLE_POS = SCI_SAMPLE_DEF
) (
  input  logic                  baud_clk,
  input  logic                  rst_n,
  input  logic                  rxd,
  input  logic                  rx_ack,
  output logic [SCI_DATA_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_busy,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int            CW       = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(OSR - 1);
`ifdef SCI_RX_MAJORITY_EN
  localparam logic [CW-1:0] CYC_S0   = CW'(SAMPLE_POS - 1);
  localparam logic [CW-1:0] CYC_S1   = CW'(SAMPLE_POS);
  localparam logic [CW-1:0] CYC_DEC  = CW'(SAMPLE_POS + 1);
`else
  localparam logic [CW-1:0] CYC_DEC  = CW'(SAMPLE_POS);
`endif

  logic rxd_s, fall_s, bit_s, sample_s, load_s, ack_s;
  logic [CW-1:0] cyc_next_s;

  sci_rx_state_e          state_q, state_d;
  logic [CW-1:0]          cyc_q, cyc_d;
  logic [2:0]             bitn_q, bitn_d;
  logic [SCI_DATA_W-1:0]  shreg_q, shreg_d;
  logic [SCI_DATA_W-1:0]  data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;

  sci_rx_sync u_sync (
    .baud_clk (baud_clk),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .rxd_s    (rxd_s),
    .fall     (fall_s)
  );

`ifdef SCI_RX_MAJORITY_EN
  logic s0_q, s0_d, s1_q, s1_d;

  // Capture the two early votes; the third is the live sample at decision time.
  always_comb begin
    s0_d  = (cyc_q == CYC_S0) ? rxd_s : s0_q;
    s1_d  = (cyc_q == CYC_S1) ? rxd_s : s1_q;
    bit_s = maj3(s0_q, s1_q, rxd_s);
  end

  // Vote registers.
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= 1'b1;
      s1_q <= 1'b1;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end
`else
  // Single-sample bit decision.
  always_comb bit_s = rxd_s;
`endif

  // Frame FSM, counters, shift register and host-side holding register.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bitn_d     = bitn_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    ferr_d     = 1'b0;
    load_s     = 1'b0;
    sample_s   = (cyc_q == CYC_DEC);
    cyc_next_s = (cyc_q == CYC_LAST) ? '0 : cyc_q + CW'(1);
    ack_s      = rx_ack & valid_q;

    case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (fall_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        cyc_d = cyc_next_s;
        if (sample_s && bit_s) begin
          state_d = IDLE;
          cyc_d   = '0;
        end else if (cyc_q == CYC_LAST) begin
          state_d = DATA;
          bitn_d  = 3'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        cyc_d = cyc_next_s;
        if (sample_s) begin
          shreg_d = {bit_s, shreg_q[SCI_DATA_W-1:1]};
        end else begin
          shreg_d = shreg_q;
        end
        if (cyc_q == CYC_LAST) begin
          bitn_d  = bitn_q + 3'd1;
          state_d = (bitn_q == 3'd7) ? STOP : DATA;
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        cyc_d = cyc_next_s;
        if (sample_s) begin
          cyc_d = '0;
          if (bit_s) begin
            load_s  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HI;
          end
        end else begin
          state_d = STOP;
        end
      end
      WAIT_HI: begin
        cyc_d = '0;
        if (rxd_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_HI;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = '0;
        bitn_d  = 3'd0;
      end
    endcase

    // A same-cycle ack and load leaves the new byte valid without flagging overrun.
    valid_d = ack_s ? 1'b0 : valid_q;
    ovr_d   = ack_s ? 1'b0 : ovr_q;
    if (load_s) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
      if (valid_q && !rx_ack) begin
        ovr_d = 1'b1;
      end else begin
        ovr_d = ovr_d;
      end
    end else begin
      data_d = data_q;
    end

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bitn_q  <= 3'd0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bitn_q  <= bitn_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = busy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_sci_rx.sv
// Scoreboard bench for sci_rx: expected bytes are queued at stimulus time and checked by a monitor on rx_valid rise.
`timescale 1ns/1ps
module tb_sci_rx;

  logic       baud_clk = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rxd      = 1'b1;
  logic       rx_ack   = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, overrun;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;

`ifdef SCI_RX_MAJORITY_EN
  localparam int         EXP_LAT    = 70;
  localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
  localparam int         EXP_LAT    = 69;
  localparam logic [7:0] GLITCH_EXP = 8'h04;
`endif

  typedef struct {
    logic [7:0] data;
    int         t0;
  } exp_t;

  exp_t exp_q[$];
  int   fe_pulses  = 0;
  int   fe_run     = 0;
  int   fe_max_run = 0;

  sci_rx dut (
    .baud_clk  (baud_clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 baud_clk = ~baud_clk;

  always @(posedge baud_clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives a frame (start, d LSB first, stop) for ncyc cycles; cycle index glitch is forced high.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int glitch,
                            input int ncyc, input bit push, input logic [7:0] exp_d);
    logic [9:0] fr;
    exp_t       e;
    fr = {stop_b, d, 1'b0};
    if (push) begin
      e.data = exp_d;
      e.t0   = cyc_cnt + 1;
      exp_q.push_back(e);
    end
    for (int i = 0; i < ncyc; i++) begin
      rxd = (i == glitch) ? 1'b1 : fr[i / 7];
      @(negedge baud_clk);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge baud_clk);
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    @(negedge baud_clk);
    rx_ack = 1'b0;
  endtask

  // Monitor: pop and compare on each new valid byte; measure frame_err pulse widths.
  initial begin : monitor
    logic valid_prev;
    exp_t e;
    valid_prev = 1'b0;
    forever begin
      @(negedge baud_clk);
      if (rst_n) begin
        if (frame_err) begin
          fe_run++;
        end else begin
          if (fe_run > 0) begin
            fe_pulses++;
            if (fe_run > fe_max_run) fe_max_run = fe_run;
          end
          fe_run = 0;
        end
        if (rx_valid && !valid_prev) begin
          check("sb_pending", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_data", rx_data, e.data);
            check("sb_latency", cyc_cnt - e.t0, EXP_LAT);
          end
        end
      end
      valid_prev = rx_valid;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (3) @(negedge baud_clk);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    rst_n = 1'b1;
    idle(4);

    // Test 1: clean byte
    send_frame(8'hA5, 1'b1, -1, 70, 1'b1, 8'hA5);
    idle(4);
    check("t1_valid", rx_valid, 1'b1);
    check("t1_data", rx_data, 8'hA5);
    check("t1_ferr", fe_pulses, 0);
    ack();
    check("t1_ack_valid", rx_valid, 1'b0);

    // Test 2: false start
    rxd = 1'b0;
    repeat (2) @(negedge baud_clk);
    rxd = 1'b1;
    repeat (2) @(negedge baud_clk);
    check("t2_busy_start", rx_busy, 1'b1);
    idle(10);
    check("t2_busy_idle", rx_busy, 1'b0);
    check("t2_valid", rx_valid, 1'b0);
    check("t2_ferr", fe_pulses, 0);
    check("t2_ovr", overrun, 1'b0);

    // Test 3: framing error then line high
    send_frame(8'h3C, 1'b0, -1, 70, 1'b0, 8'h00);
    idle(20);
    check("t3_fe_pulses", fe_pulses, 1);
    check("t3_fe_width", fe_max_run, 1);
    check("t3_valid", rx_valid, 1'b0);
    check("t3_data_held", rx_data, 8'hA5);
    check("t3_busy", rx_busy, 1'b0);

    // Test 4: back-to-back without ack
    send_frame(8'h11, 1'b1, -1, 70, 1'b1, 8'h11);
    send_frame(8'h22, 1'b1, -1, 70, 1'b0, 8'h00);
    idle(4);
    check("t4_data", rx_data, 8'h22);
    check("t4_valid", rx_valid, 1'b1);
    check("t4_ovr", overrun, 1'b1);
    ack();
    check("t4_ack_valid", rx_valid, 1'b0);
    check("t4_ack_ovr", overrun, 1'b0);
    check("t4_data_kept", rx_data, 8'h22);

    // Test 5: async reset during data bit 4
    send_frame(8'hFF, 1'b1, -1, 38, 1'b0, 8'h00);
    check("t5_busy_mid", rx_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_data", rx_data, 8'h00);
    check("t5_rst_valid", rx_valid, 1'b0);
    check("t5_rst_busy", rx_busy, 1'b0);
    check("t5_rst_ovr", overrun, 1'b0);
    repeat (2) @(negedge baud_clk);
    rst_n = 1'b1;
    idle(4);
    check("t5_no_false_start", rx_busy, 1'b0);
    send_frame(8'h5A, 1'b1, -1, 70, 1'b1, 8'h5A);
    idle(4);
    check("t5_data", rx_data, 8'h5A);
    ack();

    // Test 6: one-cycle glitch at the bit-2 sample point
    send_frame(8'h00, 1'b1, 25, 70, 1'b1, GLITCH_EXP);
    idle(4);
    check("t6_data", rx_data, GLITCH_EXP);
    ack();
    idle(4);

    check("sb_empty", exp_q.size(), 0);
    check("end_fe_pulses", fe_pulses, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
